// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit: state enum,
// 3-bit opcode map and the datapath mux select encodings.
package ctrl_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_t;

    localparam logic [2:0] OP_RTYPE = 3'd0;
    localparam logic [2:0] OP_SLT   = 3'd1;
    localparam logic [2:0] OP_J     = 3'd2;
    localparam logic [2:0] OP_JAL   = 3'd3;
    localparam logic [2:0] OP_LW    = 3'd4;
    localparam logic [2:0] OP_SW    = 3'd5;
    localparam logic [2:0] OP_BEQ   = 3'd6;
    localparam logic [2:0] OP_ADDI  = 3'd7;

    localparam logic [1:0] ALUOP_FUNCT = 2'b00;
    localparam logic [1:0] ALUOP_ADD   = 2'b01;
    localparam logic [1:0] ALUOP_SUB   = 2'b10;
    localparam logic [1:0] ALUOP_ADDI  = 2'b11;

    localparam logic [1:0] SRCB_REGB = 2'b00;
    localparam logic [1:0] SRCB_ONE  = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    localparam logic [1:0] REGDST_RT  = 2'b00;
    localparam logic [1:0] REGDST_RD  = 2'b01;
    localparam logic [1:0] REGDST_R31 = 2'b10;

    localparam logic [1:0] M2R_ALU = 2'b00;
    localparam logic [1:0] M2R_MEM = 2'b01;
    localparam logic [1:0] M2R_PC  = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_BRANCH = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/ctrl_perf_cnt.sv
// Free-running cycle counter and retired-instruction counter, both wrapping
// modulo 2^CNT_W and cleared by rst.
module ctrl_perf_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_done,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
);

    logic [CNT_W-1:0] cycle_reg;
    logic [CNT_W-1:0] instr_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_reg <= '0;
            instr_reg <= '0;
        end else begin
            cycle_reg <= cycle_reg + CNT_W'(1);
            if (instr_done) begin
                instr_reg <= instr_reg + CNT_W'(1);
            end
        end
    end

    assign cycle_cnt = cycle_reg;
    assign instr_cnt = instr_reg;

endmodule

// File: rtl/control_fsm.sv
// Multicycle control FSM: FETCH/DECODE/EXEC/MEM/WB with mem_req/mem_ack stalls.
// Define CTRL_PERF_CNT_EN to add the cycle_cnt/instr_cnt performance counters.
module control_fsm
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W = 4,
    parameter int CNT_W    = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                alu_zero,
    input  logic                mem_ack,
    output logic                pc_write,
    output logic                ir_write,
    output logic                mem_req,
    output logic                mem_we,
    output logic                sig_iord,
    output logic [1:0]          sig_ALUop,
    output logic                sig_ALUsrcA,
    output logic [1:0]          sig_ALUsrcB,
    output logic [1:0]          sig_regDst,
    output logic [1:0]          sig_memtoReg,
    output logic                sig_regWrite,
    output logic [1:0]          sig_pcSrc,
    output logic                sign_or_zero,
    output logic                illegal_op,
    output logic                instr_done
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]    cycle_cnt,
    output logic [CNT_W-1:0]    instr_cnt
`endif
);

    if (OPCODE_W < 3 || CNT_W < 1) begin : g_param_check
        $error("control_fsm: OPCODE_W must be >= 3 and CNT_W >= 1");
    end

    state_t     state_reg, state_next;
    logic [2:0] op_reg, op_next;
    logic       op_legal;

    // Only the low three bits carry the opcode map; anything above must be zero.
    if (OPCODE_W > 3) begin : g_wide_op
        assign op_legal = ~|opcode[OPCODE_W-1:3];
    end else begin : g_narrow_op
        assign op_legal = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= FETCH;
            op_reg    <= '0;
        end else begin
            state_reg <= state_next;
            op_reg    <= op_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        op_next      = op_reg;
        pc_write     = 1'b0;
        ir_write     = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        sig_iord     = 1'b0;
        sig_ALUop    = ALUOP_FUNCT;
        sig_ALUsrcA  = 1'b0;
        sig_ALUsrcB  = SRCB_REGB;
        sig_regDst   = REGDST_RT;
        sig_memtoReg = M2R_ALU;
        sig_regWrite = 1'b0;
        sig_pcSrc    = PCSRC_ALU;
        sign_or_zero = 1'b1;
        illegal_op   = 1'b0;
        instr_done   = 1'b0;

        // Reset cycle shows the FETCH request but suppresses every strobe.
        if (rst) begin
            mem_req = 1'b1;
        end else begin
            unique case (state_reg)
                FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ack) begin
                        ir_write    = 1'b1;
                        pc_write    = 1'b1;
                        sig_ALUsrcB = SRCB_ONE;
                        sig_ALUop   = ALUOP_ADD;
                        state_next  = DECODE;
                    end
                end
                DECODE: begin
                    op_next = opcode[2:0];
                    if (!op_legal) begin
                        illegal_op = 1'b1;
                        state_next = FETCH;
                    end else begin
                        state_next = EXEC;
                    end
                end
                EXEC: begin
                    unique case (op_reg)
                        OP_RTYPE, OP_SLT: begin
                            sig_ALUop   = ALUOP_FUNCT;
                            sig_ALUsrcA = 1'b1;
                            state_next  = WB;
                        end
                        OP_ADDI: begin
                            sig_ALUop   = ALUOP_ADDI;
                            sig_ALUsrcB = SRCB_IMM;
                            state_next  = WB;
                        end
                        OP_LW, OP_SW: begin
                            sig_ALUop   = ALUOP_ADD;
                            sig_ALUsrcB = SRCB_IMM;
                            state_next  = MEM;
                        end
                        OP_BEQ: begin
                            sig_ALUop  = ALUOP_SUB;
                            pc_write   = alu_zero;
                            sig_pcSrc  = PCSRC_BRANCH;
                            instr_done = 1'b1;
                            state_next = FETCH;
                        end
                        OP_J, OP_JAL: begin
                            pc_write   = 1'b1;
                            sig_pcSrc  = PCSRC_JUMP;
                            instr_done = 1'b1;
                            state_next = FETCH;
                            if (op_reg == OP_JAL) begin
                                sig_regWrite = 1'b1;
                                sig_regDst   = REGDST_R31;
                                sig_memtoReg = M2R_PC;
                            end
                        end
                        default: state_next = FETCH;
                    endcase
                end
                MEM: begin
                    mem_req  = 1'b1;
                    sig_iord = 1'b1;
                    mem_we   = (op_reg == OP_SW);
                    if (mem_ack) begin
                        if (op_reg == OP_SW) begin
                            instr_done = 1'b1;
                            state_next = FETCH;
                        end else begin
                            state_next = WB;
                        end
                    end
                end
                WB: begin
                    sig_regWrite = 1'b1;
                    instr_done   = 1'b1;
                    state_next   = FETCH;
                    if (op_reg == OP_LW) begin
                        sig_regDst   = REGDST_RT;
                        sig_memtoReg = M2R_MEM;
                    end else if (op_reg == OP_ADDI) begin
                        sig_regDst = REGDST_RT;
                    end else begin
                        sig_regDst = REGDST_RD;
                    end
                end
                default: state_next = FETCH;
            endcase
        end
    end

`ifdef CTRL_PERF_CNT_EN
    ctrl_perf_cnt #(
        .CNT_W(CNT_W)
    ) u_perf_cnt (
        .clk       (clk),
        .rst       (rst),
        .instr_done(instr_done),
        .cycle_cnt (cycle_cnt),
        .instr_cnt (instr_cnt)
    );
`endif

endmodule

// File: tb/tb_control_fsm.sv
// Table-driven bench for control_fsm: each vector runs one instruction with
// chosen memory wait states; expectations are queued and compared on retire.
module tb_control_fsm;

    localparam int TB_CNT_W = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] opcode = '0;
    logic       alu_zero = 1'b0;
    logic       mem_ack = 1'b0;
    logic       pc_write, ir_write, mem_req, mem_we, sig_iord;
    logic [1:0] sig_ALUop, sig_ALUsrcB, sig_regDst, sig_memtoReg, sig_pcSrc;
    logic       sig_ALUsrcA, sig_regWrite, sign_or_zero, illegal_op, instr_done;
`ifdef CTRL_PERF_CNT_EN
    logic [TB_CNT_W-1:0] cycle_cnt, instr_cnt;
`endif

    control_fsm #(
        .OPCODE_W(4),
        .CNT_W   (TB_CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .opcode      (opcode),
        .alu_zero    (alu_zero),
        .mem_ack     (mem_ack),
        .pc_write    (pc_write),
        .ir_write    (ir_write),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .sig_iord    (sig_iord),
        .sig_ALUop   (sig_ALUop),
        .sig_ALUsrcA (sig_ALUsrcA),
        .sig_ALUsrcB (sig_ALUsrcB),
        .sig_regDst  (sig_regDst),
        .sig_memtoReg(sig_memtoReg),
        .sig_regWrite(sig_regWrite),
        .sig_pcSrc   (sig_pcSrc),
        .sign_or_zero(sign_or_zero),
        .illegal_op  (illegal_op),
        .instr_done  (instr_done)
`ifdef CTRL_PERF_CNT_EN
        ,
        .cycle_cnt   (cycle_cnt),
        .instr_cnt   (instr_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int opc;
        int az;
        int stray;     // mem_ack level outside memory states
        int fw;        // fetch wait cycles
        int mw;        // MEM wait cycles
        int lat;
        int illegal;
        int rw_total;
        int dst;       // final-cycle sig_regDst
        int m2r;       // final-cycle sig_memtoReg
        int pcw_final;
        int pcsrc;     // final-cycle sig_pcSrc
        int pcw_total;
        int we_cyc;
    } vec_t;

    vec_t vecs[12];
    vec_t exp_q[$];
    int   pass_cnt = 0;
    int   total_cnt = 0;

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic vec_t mk(input int opc, az, stray, fw, mw, lat, illegal, rw,
                                input int dst, m2r, pcwf, pcsrc, pcwt, we);
        vec_t v;
        v.opc = opc; v.az = az; v.stray = stray; v.fw = fw; v.mw = mw; v.lat = lat;
        v.illegal = illegal; v.rw_total = rw; v.dst = dst; v.m2r = m2r;
        v.pcw_final = pcwf; v.pcsrc = pcsrc; v.pcw_total = pcwt; v.we_cyc = we;
        return v;
    endfunction

    // Entered just after a rising edge with the FSM in FETCH.
    task automatic run_instr(input int idx, input vec_t v);
        int   cyc = 0, fcnt = 0, mcnt = 0;
        int   rw = 0, pcw = 0, we = 0, irw = 0, ill = 0;
        int   dst = 0, m2r = 0, pcwf = 0, pcs = 0;
        bit   finished = 0;
        vec_t e;
        opcode   = 4'(v.opc);
        alu_zero = v.az[0];
        exp_q.push_back(v);
        while (!finished && cyc < 40) begin
            if (mem_req && !sig_iord) begin
                mem_ack = (fcnt == v.fw); fcnt++;
            end else if (mem_req && sig_iord) begin
                mem_ack = (mcnt == v.mw); mcnt++;
            end else begin
                mem_ack = v.stray[0];
            end
            @(negedge clk);
            cyc++;
            rw  += int'(sig_regWrite);
            pcw += int'(pc_write);
            we  += int'(mem_we);
            irw += int'(ir_write);
            ill += int'(illegal_op);
            if (instr_done || illegal_op) begin
                finished = 1;
                dst  = int'(sig_regDst);
                m2r  = int'(sig_memtoReg);
                pcwf = int'(pc_write);
                pcs  = int'(sig_pcSrc);
            end
            @(posedge clk);
            #1;
        end
        mem_ack = 1'b0;
        if (!finished) check($sformatf("v%0d timeout", idx), 0, 1);
        e = exp_q.pop_front();
        check($sformatf("v%0d cycles", idx), cyc, e.lat);
        check($sformatf("v%0d illegal_op", idx), ill, e.illegal);
        check($sformatf("v%0d regWrite count", idx), rw, e.rw_total);
        check($sformatf("v%0d regDst", idx), dst, e.dst);
        check($sformatf("v%0d memtoReg", idx), m2r, e.m2r);
        check($sformatf("v%0d final pc_write", idx), pcwf, e.pcw_final);
        check($sformatf("v%0d pcSrc", idx), pcs, e.pcsrc);
        check($sformatf("v%0d pc_write count", idx), pcw, e.pcw_total);
        check($sformatf("v%0d mem_we cycles", idx), we, e.we_cyc);
        check($sformatf("v%0d ir_write count", idx), irw, 1);
        $display("vec %0d: opcode %0d fw %0d mw %0d -> %0d cycles", idx, v.opc, v.fw, v.mw, cyc);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        mem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        //           opc az st fw mw lat ill rw dst m2r pcwf pcs pcwt we
        vecs[0]  = mk(0, 0, 0, 0, 0, 4, 0, 1, 1, 0, 0, 0, 1, 0);  // R-type
        vecs[1]  = mk(1, 1, 1, 0, 0, 4, 0, 1, 1, 0, 0, 0, 1, 0);  // slt, stray acks
        vecs[2]  = mk(2, 0, 0, 0, 0, 3, 0, 0, 0, 0, 1, 2, 2, 0);  // j
        vecs[3]  = mk(3, 0, 1, 0, 0, 3, 0, 1, 2, 2, 1, 2, 2, 0);  // jal
        vecs[4]  = mk(4, 0, 0, 0, 0, 5, 0, 1, 0, 1, 0, 0, 1, 0);  // lw
        vecs[5]  = mk(5, 0, 0, 0, 3, 7, 0, 0, 0, 0, 0, 0, 1, 4);  // sw, 3 waits
        vecs[6]  = mk(6, 1, 0, 0, 0, 3, 0, 0, 0, 0, 1, 1, 2, 0);  // beq taken
        vecs[7]  = mk(6, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 1, 1, 0);  // beq not taken
        vecs[8]  = mk(7, 0, 0, 2, 0, 6, 0, 1, 0, 0, 0, 0, 1, 0);  // addi, fetch waits
        vecs[9]  = mk(9, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0, 1, 0);  // illegal
        vecs[10] = mk(15, 0, 1, 1, 0, 3, 1, 0, 0, 0, 0, 0, 1, 0); // illegal, fetch wait
        vecs[11] = mk(4, 0, 0, 1, 2, 8, 0, 1, 0, 1, 0, 0, 1, 0);  // lw, waits

        // Reset held with mem_ack high: no strobes, FETCH request visible.
        rst = 1'b1;
        mem_ack = 1'b1;
        @(negedge clk);
        check("reset mem_req", int'(mem_req), 1);
        check("reset strobes", int'({ir_write, pc_write, sig_regWrite, mem_we, instr_done, illegal_op}), 0);
        check("reset sign_or_zero", int'(sign_or_zero), 1);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        mem_ack = 1'b0;
        #1;
        check("post-reset mem_req", int'(mem_req), 1);
        check("post-reset iord", int'(sig_iord), 0);
        check("post-reset outputs", int'({ir_write, pc_write, sig_regWrite, mem_we, instr_done,
                                          illegal_op, sig_ALUop, sig_ALUsrcB, sig_pcSrc}), 0);
        $display("reset: mem_req=%0b sign_or_zero=%0b", mem_req, sign_or_zero);

        // sw aborted by reset while stalled in MEM.
        opcode = 4'd5;
        mem_ack = 1'b1;
        @(posedge clk); #1 mem_ack = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        check("midop in MEM mem_we", int'(mem_we), 1);
        rst = 1'b1;
        mem_ack = 1'b1;
        #1;
        check("midop reset strobes", int'({ir_write, pc_write, sig_regWrite, mem_we, instr_done}), 0);
        check("midop reset iord", int'(sig_iord), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        mem_ack = 1'b0;
        #1;
        check("midop back in FETCH", int'({mem_req, sig_iord, mem_we}), 4);
        $display("mid-op reset: mem_req=%0b iord=%0b", mem_req, sig_iord);
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) begin
            run_instr(i, vecs[i]);
        end

`ifdef CTRL_PERF_CNT_EN
        apply_reset();
        #1;
        check("cnt reset cycle", int'(cycle_cnt), 0);
        check("cnt reset instr", int'(instr_cnt), 0);
        for (int i = 0; i < 10; i++) begin
            run_instr(100 + i, vecs[8].fw == 2 ? mk(7, 0, 0, 0, 0, 4, 0, 1, 0, 0, 0, 0, 1, 0) : vecs[8]);
        end
        check("cnt cycle after 10 addi", int'(cycle_cnt), 40 % 16);
        check("cnt instr after 10 addi", int'(instr_cnt), 10);
        for (int i = 0; i < 6; i++) begin
            run_instr(110 + i, mk(7, 0, 0, 0, 0, 4, 0, 1, 0, 0, 0, 0, 1, 0));
        end
        check("cnt instr wrap", int'(instr_cnt), 0);
        check("cnt cycle wrap", int'(cycle_cnt), 64 % 16);
        $display("counters: cycle_cnt=%0d instr_cnt=%0d", cycle_cnt, instr_cnt);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/control_fsm.md
# control_fsm

Parametrised multicycle control unit for the MIPS core. It replaces the single-cycle opcode decoder with a registered state machine that sequences fetch, decode, execute, memory and write-back. Memory accesses stall on a request/acknowledge handshake. Undefined opcodes are flagged and squashed. It sits between the instruction register opcode field and the datapath muxes, register file, ALU control and the shared instruction/data memory port.

## Interface
- OPCODE_W, 4: opcode field width; must be ≥3.
- CNT_W, 32: performance counter width. Used only when the counter feature is compiled in.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- opcode  in  OPCODE_W  opcode field of the instruction register.
- alu_zero  in  1  ALU zero flag, used for beq.
- mem_ack  in  1  memory completes the current request this cycle.
- pc_write  out  1  load PC.
- ir_write  out  1  load instruction register.
- mem_req  out  1  memory request; held until mem_ack.
- mem_we  out  1  memory write qualifier, valid with mem_req.
- sig_iord  out  1  memory address source: 0 = PC, 1 = ALU result register.
- sig_ALUop  out  2  00 funct-decoded, 01 add, 10 subtract, 11 add-immediate.
- sig_ALUsrcA  out  1  ALU A operand: 0 = PC, 1 = register A.
- sig_ALUsrcB  out  2  ALU B operand: 00 = register B, 01 = constant 1, 10 = immediate.
- sig_regDst  out  2  destination register: 00 = rt, 01 = rd, 10 = r31.
- sig_memtoReg  out  2  write-back data: 00 = ALU, 01 = memory, 10 = PC.
- sig_regWrite  out  1  register file write enable.
- sig_pcSrc  out  2  next PC: 00 = ALU, 01 = branch target, 10 = jump target.
- sign_or_zero  out  1  immediate extension: 1 = sign-extend.
- illegal_op  out  1  one-cycle pulse on an undefined opcode.
- instr_done  out  1  one-cycle pulse in the final cycle of each retired instruction.

## Operation
- Opcode map: 0 R-type (add/sub/and/or), 1 slt, 2 j, 3 jal, 4 lw, 5 sw, 6 beq, 7 addi. Every value ≥8 is illegal.
- Opcode decode is combinational in DECODE. The next state is registered.
- State encoding lives in the package: FETCH, DECODE, EXEC, MEM, WB.
- FETCH:
  - mem_req=1, sig_iord=0.
  - On mem_ack: ir_write=1, pc_write=1, sig_ALUsrcA=0, sig_ALUsrcB=01, sig_ALUop=01, sig_pcSrc=00; go to DECODE.
  - Without mem_ack, stay in FETCH with mem_req held.
- DECODE:
  - Illegal opcode: illegal_op=1, go to FETCH. No write of any kind occurs.
  - Otherwise go to EXEC.
- EXEC:
  - R-type/slt: sig_ALUop=00, sig_ALUsrcA=1; go to WB.
  - addi: sig_ALUop=11, sig_ALUsrcB=10; go to WB.
  - lw/sw: sig_ALUop=01, sig_ALUsrcB=10; go to MEM.
  - beq: sig_ALUop=10, pc_write=alu_zero, sig_pcSrc=01, instr_done=1; go to FETCH.
  - j: pc_write=1, sig_pcSrc=10, instr_done=1; go to FETCH.
  - jal: as j, plus sig_regWrite=1, sig_regDst=10, sig_memtoReg=10, instr_done=1; go to FETCH.
- MEM:
  - mem_req=1, sig_iord=1, mem_we=1 for sw.
  - On mem_ack: sw sets instr_done=1 and goes to FETCH; lw goes to WB.
- WB:
  - sig_regWrite=1, instr_done=1; go to FETCH.
  - sig_regDst: 01 for R-type/slt, 00 for lw/addi.
  - sig_memtoReg: 01 for lw, else 00.
- Opcode capture: the opcode is captured into a register in DECODE. EXEC, MEM and WB use the captured value.
- Default outputs: every output not named in a state is 0, except sign_or_zero=1.

## Timing
- Reset: state=FETCH and the opcode register cleared. Every output is 0 except sign_or_zero=1 and mem_req=1.
  - mem_req=1 follows from FETCH being the reset state.
- Reset mid-operation: reset taken in any state aborts the instruction. No write strobe is asserted in the reset cycle.
- Latencies with zero-wait memory (mem_ack in the first cycle of each request):
  - j, jal, beq: 3 cycles.
  - R-type, slt, addi, sw: 4 cycles.
  - lw: 5 cycles.
  - Illegal opcode: 2 cycles.
- Wait states: each wait cycle adds one cycle. Outputs stay stable while waiting.
- mem_ack seen outside FETCH or MEM: ignored.
- beq with alu_zero=0: instr_done=1 and pc_write=0.

## Configuration
- CTRL_PERF_CNT_EN defined:
  - Adds outputs cycle_cnt and instr_cnt, each CNT_W bits.
  - Both counters clear on rst.
  - cycle_cnt increments every non-reset cycle.
  - instr_cnt increments on instr_done.
  - Both wrap modulo 2^CNT_W.
- CTRL_PERF_CNT_EN undefined: the counter ports and logic are absent.

## Structure
- Package ctrl_pkg holds:
  - The state enum.
  - Opcode constants OP_RTYPE through OP_ADDI.
  - Encodings for ALUop, ALUsrcB, regDst, memtoReg and pcSrc.
- Sub-module ctrl_perf_cnt: holds the two counters. It is instantiated only under CTRL_PERF_CNT_EN.

## Test plan
- rst=1 for 2 cycles, then release → state FETCH, mem_req=1, all write strobes 0, sign_or_zero=1.
- lw (opcode 4), mem_ack held at 1 → 5 cycles, with sig_memtoReg=01 and sig_regWrite=1 in cycle 5, instr_done=1 exactly once.
- sw with mem_ack delayed 3 cycles in MEM → mem_we=1 held for 4 cycles, total 7 cycles, no sig_regWrite.
- beq: with alu_zero=1 → pc_write=1 and sig_pcSrc=01 in cycle 3; with alu_zero=0 → pc_write=0 and instr_done=1.
- Opcode 9 → illegal_op pulses in cycle 2, back in FETCH in cycle 3, no pc_write in DECODE, no regWrite.
- With CTRL_PERF_CNT_EN: run 10 addi instructions → instr_cnt=10, cycle_cnt=40. With CNT_W=4, counters wrap to 0 after 16 increments.
